// File: rtl/sum_sq_accum.sv
// Streaming sum-of-squares accumulator: squares signed elements, accumulates
// until last_in, and emits one saturated record per vector with fixed latency 3.
module sum_sq_accum #(
  parameter int unsigned id_width   = 20,
  parameter int unsigned elem_width = 16,
  parameter int unsigned cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [elem_width-1:0] elem_in,
  input  logic                  last_in,
  input  logic [id_width-1:0]   vec_id,
  output logic [31:0]           dot_sum,
  output logic [id_width-1:0]   id_out,
  output logic [cnt_width-1:0]  len_out,
  output logic                  sat_out,
  output logic                  valid_out
);

  localparam int unsigned prod_width = 2 * elem_width;
  localparam int unsigned acc_width  = 31;
  localparam int unsigned nxt_width  = 33;
  localparam logic [acc_width-1:0] acc_max = {acc_width{1'b1}};

  typedef enum logic [0:0] {
    FIRST = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   first_tag;

  // Stage 1 registers
  logic                  s1_valid;
  logic [elem_width-1:0] s1_elem;
  logic                  s1_last;
  logic                  s1_first;
  logic [id_width-1:0]   s1_id;

  // Stage 2 registers
  logic                  s2_valid;
  logic [prod_width-1:0] s2_sq;
  logic                  s2_last;
  logic                  s2_first;
  logic [id_width-1:0]   s2_id;

  // Running per-vector state
  logic [acc_width-1:0]  acc;
  logic [cnt_width-1:0]  cnt;
  logic                  sat;
  logic [id_width-1:0]   id_cap;

  // Stage 3 combinational results
  logic signed [prod_width-1:0] prod;
  logic [acc_width-1:0]  acc_base;
  logic [nxt_width-1:0]  acc_sum;
  logic                  over;
  logic [acc_width-1:0]  acc_next;
  logic                  sat_next;
  logic [cnt_width-1:0]  cnt_base;
  logic [cnt_width-1:0]  cnt_next;
  logic [id_width-1:0]   id_next;
  logic                  emit;

  // Framing FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FIRST;
    end else begin
      state <= state_next;
    end
  end

  // Framing FSM: next state; idle cycles never move the frame
  always_comb begin
    state_next = state;
    if (valid_in) begin
      state_next = last_in ? FIRST : ACCUM;
    end
  end

  // Framing FSM: output decode
  always_comb begin
    first_tag = 1'b0;
    if (state == FIRST) begin
      first_tag = 1'b1;
    end
  end

  // S1: capture element, framing tags and the ID of a new vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_elem  <= '0;
      s1_last  <= 1'b0;
      s1_first <= 1'b0;
      s1_id    <= '0;
    end else begin
      s1_valid <= valid_in;
      if (valid_in) begin
        s1_elem  <= elem_in;
        s1_last  <= last_in;
        s1_first <= first_tag;
        if (first_tag) begin
          s1_id <= vec_id;
        end
      end
    end
  end

  // Square is never negative, so the signed product is reused as unsigned
  assign prod = $signed(s1_elem) * $signed(s1_elem);

  // S2: register the square
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sq    <= '0;
      s2_last  <= 1'b0;
      s2_first <= 1'b0;
      s2_id    <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sq    <= $unsigned(prod);
        s2_last  <= s1_last;
        s2_first <= s1_first;
        s2_id    <= s1_id;
      end
    end
  end

  // S3: a first element restarts acc/cnt/sat in the same cycle it is used
  always_comb begin
    acc_base = s2_first ? '0 : acc;
    acc_sum  = nxt_width'(acc_base) + nxt_width'(s2_sq);
    over     = (acc_sum[nxt_width-1:acc_width] != '0);
    acc_next = over ? acc_max : acc_sum[acc_width-1:0];
    sat_next = over | (s2_first ? 1'b0 : sat);
    cnt_base = s2_first ? '0 : cnt;
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + cnt_width'(1);
    id_next  = s2_first ? s2_id : id_cap;
    emit     = s2_valid & s2_last;
  end

  // Accumulator state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      sat    <= 1'b0;
      id_cap <= '0;
    end else if (s2_valid) begin
      acc    <= acc_next;
      cnt    <= cnt_next;
      sat    <= sat_next;
      id_cap <= id_next;
    end
  end

  // Output record; payload holds between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dot_sum   <= '0;
      id_out    <= '0;
      len_out   <= '0;
      sat_out   <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= emit;
      if (emit) begin
        dot_sum <= {1'b0, acc_next};
        id_out  <= id_next;
        len_out <= cnt_next;
        sat_out <= sat_next;
      end
    end
  end

endmodule

// File: tb/tb_sum_sq_accum.sv
// Scoreboard bench for sum_sq_accum: directed vectors with hand-computed
// records plus a random stream checked against a saturating reference model.
module tb_sum_sq_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] elem_in = '0;
  logic        last_in = 1'b0;
  logic [19:0] vec_id = '0;
  logic [31:0] dot_sum;
  logic [19:0] id_out;
  logic [15:0] len_out;
  logic        sat_out;
  logic        valid_out;

  sum_sq_accum #(.id_width(20), .elem_width(16), .cnt_width(16)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .elem_in(elem_in),
    .last_in(last_in), .vec_id(vec_id), .dot_sum(dot_sum), .id_out(id_out),
    .len_out(len_out), .sat_out(sat_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint dot;
    longint id;
    longint len;
    longint sat;
    longint cyc;
  } rec_t;

  rec_t   sb[$];
  longint cyc = 0;
  longint last_cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_last = 0;
  int     n_strobe = 0;

  // Reference model state
  bit     use_model = 0;
  bit     m_first = 1;
  longint m_acc, m_cnt, m_sat, m_id;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input longint dot, input longint id, input longint len, input longint sat);
    rec_t r;
    r.dot = dot; r.id = id; r.len = len; r.sat = sat; r.cyc = last_cyc + 3;
    sb.push_back(r);
  endtask

  task automatic send(input int e, input bit last, input logic [19:0] id);
    @(negedge clk);
    valid_in = 1'b1;
    elem_in  = 16'(e);
    last_in  = last;
    vec_id   = id;
    last_cyc = cyc;
    if (last) n_last++;
    if (m_first) begin
      m_acc = 0; m_cnt = 0; m_sat = 0; m_id = longint'(id);
    end
    m_acc = m_acc + longint'(e) * longint'(e);
    if (m_acc > 64'h7FFF_FFFF) begin
      m_acc = 64'h7FFF_FFFF;
      m_sat = 1;
    end
    if (m_cnt < 65535) m_cnt++;
    m_first = last;
    if (last && use_model) push(m_acc, m_id, m_cnt, m_sat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      elem_in  = 16'hDEAD;
      last_in  = 1'b1;
      vec_id   = 20'hFFFFF;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dot"}, longint'(dot_sum), 0);
    chk({tag, "_id"},  longint'(id_out), 0);
    chk({tag, "_len"}, longint'(len_out), 0);
    chk({tag, "_sat"}, longint'(sat_out), 0);
    chk({tag, "_vld"}, longint'(valid_out), 0);
  endtask

  // Monitor: every strobe must match the oldest expected record
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      n_strobe++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got dot 0x%0h id 0x%0h expected no output (cycle %0d)",
                 dot_sum, id_out, cyc);
      end else begin
        rec_t r;
        r = sb.pop_front();
        chk("dot_sum", longint'(dot_sum), r.dot);
        chk("id_out",  longint'(id_out),  r.id);
        chk("len_out", longint'(len_out), r.len);
        chk("sat_out", longint'(sat_out), r.sat);
        chk("latency_cycle", cyc, r.cyc);
      end
    end
  end

  initial begin
    int len, amp, e;
    logic [19:0] id;

    repeat (3) @(negedge clk);
    #1 chk_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 3, -4 -> 25
    send(3, 0, 20'h00005);
    send(-4, 1, 20'h0ABCD);
    push(25, 20'h00005, 2, 0);
    idle(4);
    chk("hold_dot_sum", longint'(dot_sum), 25);
    chk("hold_valid_low", longint'(valid_out), 0);

    // Single -32768, then back-to-back {1,1}
    send(-32768, 1, 20'h11111);
    push(64'h4000_0000, 20'h11111, 1, 0);
    send(1, 0, 20'h22222);
    send(1, 1, 20'h33333);
    push(2, 20'h22222, 2, 0);
    idle(3);

    // Saturation, then sticky sat clears on next vector
    send(-32768, 0, 20'h44444);
    send(-32768, 0, 20'h00000);
    send(-32768, 1, 20'h00000);
    push(64'h7FFF_FFFF, 20'h44444, 3, 1);
    send(2, 1, 20'h55555);
    push(4, 20'h55555, 1, 0);
    idle(3);

    // Gaps inside a vector; later IDs ignored
    send(1, 0, 20'h66666);
    idle(2);
    send(2, 0, 20'h77777);
    idle(2);
    send(3, 1, 20'h88888);
    push(14, 20'h66666, 3, 0);
    idle(5);

    // Reset mid-vector discards the partial vector
    send(5, 0, 20'h99999);
    send(5, 0, 20'h99999);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b1;
    #1 chk_zero("in_reset");
    @(negedge clk);
    rst = 1'b0;
    m_first = 1;
    send(6, 1, 20'hAAAAA);
    push(36, 20'hAAAAA, 1, 0);
    idle(4);

    // Random stream checked against the reference model
    use_model = 1;
    for (int v = 0; v < 1000; v++) begin
      len = int'($urandom_range(1, 64));
      case ($urandom_range(0, 3))
        0: amp = 15;
        1: amp = 255;
        2: amp = 4095;
        default: amp = 32767;
      endcase
      id = 20'($urandom);
      for (int i = 0; i < len; i++) begin
        if (amp == 32767 && $urandom_range(0, 7) == 0) e = -32768;
        else e = int'($urandom_range(0, 2 * amp)) - amp;
        send(e, (i == len - 1), (i == 0) ? id : 20'($urandom));
        if ($urandom_range(0, 15) == 0) idle(1);
      end
    end
    idle(1);

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    idle(2);
    chk("scoreboard_drained", longint'(sb.size()), 0);
    chk("strobe_count", longint'(n_strobe), longint'(n_last));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
